dfp_line_mem: RTL and testbench

//   Memory-side responder for the cache's downward-facing port (dfp): services 256-bit line reads/writes

---
 rtl/dfp_line_mem.sv | 187 ++++++++++++++++++
 tb/tb_dfp_line_mem.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_line_mem.sv
`default_nettype none
// ============================================================================
// Module      : dfp_line_mem
// Description : Memory-side responder for a cache's downward-facing port.
//               Services 256-bit line reads/writes from an internal line
//               store with a fixed, parameterised latency. Lines never
//               written since reset read back an address-derived pattern.
//               Protocol violations by the requester raise a sticky flag.
// Ports       : clk        - clock, all logic on posedge
//               rst        - synchronous active-high reset
//               dfp_addr   - line address, bits [4:0] expected zero
//               dfp_read   - read request, held until dfp_resp
//               dfp_write  - write request, held until dfp_resp
//               dfp_wdata  - write line, word i in [i*32 +: 32]
//               dfp_rdata  - read line, non-zero only during a read resp
//               dfp_resp   - one-cycle completion pulse
//               proto_err  - sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module dfp_line_mem #(
    parameter int LINES   = 1024,   // power of two
    parameter int LATENCY = 4       // 1..255 cycles from acceptance to resp
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic         proto_err
);

    localparam int         c_IDX_W  = $clog2(LINES);
    localparam logic [7:0] c_LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [7:0]           r_cnt;
    logic [31:0]          r_addr;
    logic                 r_op_write;
    logic [255:0]         r_wdata;
    logic                 r_proto_err;
    logic [LINES-1:0]     r_valid;
    logic [255:0]         r_mem [LINES];
    logic [255:0]         r_rd_line;
    logic                 r_rd_hit;

    logic                 w_req;
    logic                 w_accept;
    logic                 w_busy;
    logic [c_IDX_W-1:0]   w_idx_now;
    logic [c_IDX_W-1:0]   w_idx_lat;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [255:0]         w_pattern;
    logic                 w_both;
    logic                 w_misalign;
    logic                 w_changed;
    logic                 w_commit;

    assign w_req     = dfp_read | dfp_write;
    assign w_accept  = (r_state == S_IDLE) && w_req;
    assign w_busy    = (r_state == S_WAIT) || (r_state == S_RESP);
    assign w_idx_now = dfp_addr[5 +: c_IDX_W];
    assign w_idx_lat = r_addr[5 +: c_IDX_W];
    assign w_commit  = (r_state == S_RESP) && r_op_write;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd1) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_accept) begin
            r_cnt <= c_LAT_M1;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Request capture; the FSM reset alone discards a pending request.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_addr     <= dfp_addr;
            r_op_write <= dfp_write;
            r_wdata    <= dfp_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Line store. The read is captured on the edge entering RESP, so the
    // array sees a registered read port. When LATENCY==1 that edge is the
    // acceptance edge itself, hence the index comes from the live address.
    // A write commits on the edge leaving RESP, which can never coincide
    // with a later request's entry into RESP.
    // ------------------------------------------------------------------
    assign w_rd_idx = (r_state == S_IDLE) ? w_idx_now : w_idx_lat;

    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            r_mem[w_idx_lat] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_commit) begin
            r_valid[w_idx_lat] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_next_state == S_RESP) begin
            r_rd_line <= r_mem[w_rd_idx];
            r_rd_hit  <= r_valid[w_rd_idx];
        end
    end

    // Never-written lines return word i = line base address + 4*i.
    always_comb begin
        w_pattern = '0;
        for (int i = 0; i < 8; i++) begin
            w_pattern[i*32 +: 32] = {r_addr[31:5], 5'b0} + 32'(i * 4);
        end
    end

    assign dfp_resp  = (r_state == S_RESP);
    assign dfp_rdata = (dfp_resp && !r_op_write) ?
                       (r_rd_hit ? r_rd_line : w_pattern) : '0;

    // ------------------------------------------------------------------
    // Protocol monitor: flags only, never influences the FSM.
    // ------------------------------------------------------------------
    assign w_both     = dfp_read & dfp_write;
    assign w_misalign = w_accept && (dfp_addr[4:0] != 5'd0);
    assign w_changed  = w_busy &&
                        (!w_req ||
                         (dfp_addr != r_addr) ||
                         (dfp_write != r_op_write) ||
                         (r_op_write && (dfp_wdata != r_wdata)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (w_both || w_misalign || w_changed) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_dfp_line_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfp_line_mem
// Description : Self-checking bench for dfp_line_mem. A LATENCY=4 instance
//               takes directed and randomised line traffic checked against
//               a line-level model; a LATENCY=1 instance covers the
//               minimum-latency back-to-back case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfp_line_mem;

    localparam int c_LAT = 4;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         proto_err;

    logic [31:0]  addr1;
    logic         read1;
    logic         write1;
    logic [255:0] wdata1;
    logic [255:0] rdata1;
    logic         resp1;
    logic         proto_err1;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a line is present only once written since the last reset.
    logic [255:0] m_line [int];

    dfp_line_mem #(.LINES(1024), .LATENCY(c_LAT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .dfp_addr  (dfp_addr),
        .dfp_read  (dfp_read),
        .dfp_write (dfp_write),
        .dfp_wdata (dfp_wdata),
        .dfp_rdata (dfp_rdata),
        .dfp_resp  (dfp_resp),
        .proto_err (proto_err)
    );

    dfp_line_mem #(.LINES(16), .LATENCY(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .dfp_addr  (addr1),
        .dfp_read  (read1),
        .dfp_write (write1),
        .dfp_wdata (wdata1),
        .dfp_rdata (rdata1),
        .dfp_resp  (resp1),
        .proto_err (proto_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_read(input logic [31:0] a);
        logic [255:0] r;
        int idx;
        idx = int'(a[14:5]);
        if (m_line.exists(idx)) begin
            r = m_line[idx];
        end else begin
            for (int i = 0; i < 8; i++) begin
                r[i*32 +: 32] = {a[31:5], 5'b0} + 32'(4 * i);
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dfp_read = 1'b0; dfp_write = 1'b0; read1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_line.delete();
    endtask

    // Counts negedges until the selected resp is seen (bounded).
    task automatic wait_resp(input bit sel, output int n);
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = sel ? resp1 : dfp_resp;
        end
    endtask

    // One complete transaction on the main instance, checked against the model.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] wd,
                       input string tag, output logic [255:0] rd);
        int n;
        @(negedge clk);
        dfp_addr = a; dfp_read = !wr; dfp_write = wr; dfp_wdata = wd;
        wait_resp(1'b0, n);
        chk({tag, " latency"}, 256'(n), 256'(c_LAT));
        rd = dfp_rdata;
        chk({tag, " rdata"}, dfp_rdata, wr ? 256'd0 : model_read(a));
        if (wr) m_line[int'(a[14:5])] = wd;
        @(negedge clk);
        chk({tag, " pulse"}, 256'(dfp_resp), 256'd0);
        dfp_read = 1'b0; dfp_write = 1'b0;
    endtask

    initial begin
        logic [255:0] rd;
        logic [255:0] wd;
        logic [31:0]  a;
        logic [9:0]   idx_pool [4];
        int           n;
        bit           seen;

        rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        addr1 = '0; read1 = 1'b0; write1 = 1'b0; wdata1 = '0;
        idx_pool[0] = 10'd0; idx_pool[1] = 10'd1; idx_pool[2] = 10'd513; idx_pool[3] = 10'd1023;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset resp", 256'(dfp_resp), 256'd0);
        chk("reset rdata", dfp_rdata, 256'd0);
        chk("reset proto_err", 256'(proto_err), 256'd0);
        rst = 1'b0;
        m_line.delete();

        // 1: unwritten line returns address pattern
        txn(1'b0, 32'h0000_1000, '0, "t1 read", rd);
        chk("t1 word0", 256'(rd[31:0]), 256'(32'h0000_1000));
        chk("t1 word7", 256'(rd[255:224]), 256'(32'h0000_101C));

        // 2: write then read back
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'hA0 + 32'(i);
        txn(1'b1, 32'h0000_2000, wd, "t2 write", rd);
        txn(1'b0, 32'h0000_2000, '0, "t2 read", rd);
        chk("t2 word3", 256'(rd[127:96]), 256'(32'hA3));
        chk("t2 proto_err", 256'(proto_err), 256'd0);

        // 3: aliasing modulo LINES
        for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'h5500 + 32'(i);
        txn(1'b1, 32'h0000_0000, wd, "t3 write", rd);
        txn(1'b0, 32'h0000_8000, '0, "t3 alias read", rd);
        chk("t3 word7", 256'(rd[255:224]), 256'(32'h5507));

        // 4: back-to-back on held read
        @(negedge clk);
        dfp_addr = 32'h0000_0040; dfp_read = 1'b1;
        wait_resp(1'b0, n);
        chk("t4 first latency", 256'(n), 256'(c_LAT));
        wait_resp(1'b0, n);
        chk("t4 spacing", 256'(n), 256'(c_LAT + 1));
        chk("t4 second rdata", dfp_rdata, model_read(32'h0000_0040));
        @(negedge clk);
        dfp_read = 1'b0;
        chk("t4 proto_err", 256'(proto_err), 256'd0);

        // 4b: LATENCY=1 instance, held read
        @(negedge clk);
        addr1 = 32'h0000_0040; read1 = 1'b1;
        wait_resp(1'b1, n);
        chk("t4 lat1 first", 256'(n), 256'd1);
        chk("t4 lat1 word0", 256'(rdata1[31:0]), 256'(32'h0000_0040));
        wait_resp(1'b1, n);
        chk("t4 lat1 spacing", 256'(n), 256'd2);
        @(negedge clk);
        read1 = 1'b0;
        chk("t4 lat1 proto_err", 256'(proto_err1), 256'd0);

        // Randomised traffic against the model
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            a[14:5] = idx_pool[$urandom_range(0, 3)];
            a[4:0] = 5'd0;
            for (int i = 0; i < 8; i++) wd[i*32 +: 32] = $urandom;
            txn(1'($urandom_range(0, 1)), a, wd, "rand", rd);
        end
        chk("rand proto_err", 256'(proto_err), 256'd0);

        // rst together with a request: request accepted only after rst drops
        @(negedge clk);
        rst = 1'b1; dfp_addr = 32'h0000_0100; dfp_read = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_line.delete();
        wait_resp(1'b0, n);
        chk("rst+req latency", 256'(n), 256'(c_LAT));
        chk("rst+req rdata", dfp_rdata, model_read(32'h0000_0100));
        @(negedge clk);
        dfp_read = 1'b0;

        // 6: reset during WAIT of a write discards it
        @(negedge clk);
        dfp_addr = 32'h0000_3000; dfp_write = 1'b1; dfp_wdata = {8{32'hDEAD_BEEF}};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; dfp_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_line.delete();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen |= dfp_resp;
        end
        chk("t6 no resp", 256'(seen), 256'd0);
        txn(1'b0, 32'h0000_3000, '0, "t6 read", rd);
        chk("t6 word0", 256'(rd[31:0]), 256'(32'h0000_3000));

        // 5a: read+write together
        do_reset();
        @(negedge clk);
        dfp_addr = 32'h0000_0500; dfp_read = 1'b1; dfp_write = 1'b1; dfp_wdata = '0;
        @(negedge clk);
        dfp_read = 1'b0; dfp_write = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5 both proto_err", 256'(proto_err), 256'd1);

        // 5b: address change in WAIT; request still completes on time
        do_reset();
        chk("t5 cleared", 256'(proto_err), 256'd0);
        @(negedge clk);
        dfp_addr = 32'h0000_0600; dfp_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dfp_addr = 32'h0000_0620;
        @(negedge clk);
        dfp_addr = 32'h0000_0600;
        @(negedge clk);
        chk("t5 resp on time", 256'(dfp_resp), 256'd1);
        chk("t5 word0", 256'(dfp_rdata[31:0]), 256'(32'h0000_0600));
        @(negedge clk);
        dfp_read = 1'b0;
        chk("t5 addr proto_err", 256'(proto_err), 256'd1);
        repeat (10) @(negedge clk);
        chk("t5 sticky", 256'(proto_err), 256'd1);
        do_reset();
        chk("t5 rst clears", 256'(proto_err), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
